// File: rtl/avst_adder_pkg.sv
// Shared parameters, state type and arithmetic helpers for the Avalon-ST packet summer.
package avst_adder_pkg;

    localparam int DEF_DATA_W = 8;
    localparam int DEF_SUM_W  = 16;
    localparam int MAX_SUM_W  = 64;

    typedef enum logic {
        SER_IDLE,
        SER_SEND
    } ser_state_e;

    function automatic int nbeats(input int sum_w, input int data_w);
        return sum_w / data_w;
    endfunction

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int DEF_NBEATS = nbeats(DEF_SUM_W, DEF_DATA_W);
    localparam int DEF_IDX_W  = idx_width(DEF_NBEATS);

    // Returns {ovf, sum}; only the low sum_w bits of sum are meaningful.
    function automatic logic [MAX_SUM_W:0] sat_add(
        input logic [MAX_SUM_W-1:0] acc,
        input logic [MAX_SUM_W-1:0] din,
        input int                   sum_w,
        input logic                 saturate
    );
        logic [MAX_SUM_W:0] one;
        logic [MAX_SUM_W:0] full;
        logic [MAX_SUM_W:0] mask;
        logic [MAX_SUM_W:0] res;
        logic               ovf;
        one  = (MAX_SUM_W+1)'(1);
        full = {1'b0, acc} + {1'b0, din};
        mask = (one << sum_w) - one;
        ovf  = (full > mask);
        if (!ovf)
            res = full;
        else if (saturate)
            res = mask;
        else
            res = full & mask;
        return {ovf, res[MAX_SUM_W-1:0]};
    endfunction

endpackage

// File: rtl/avst_sum_serializer.sv
// Drains one SUM_W-bit result as NBEATS Avalon-ST beats, LSB beat first, under full backpressure.
module avst_sum_serializer
    import avst_adder_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int SUM_W  = DEF_SUM_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load,
    input  logic [SUM_W-1:0]  load_sum,
    input  logic              load_ovf,
    input  logic              ready_out,
    output logic [DATA_W-1:0] data_out,
    output logic              valid_out,
    output logic              end_out,
    output logic              ovf_out,
    output logic              last_xfer
);

    localparam int NBEATS = nbeats(SUM_W, DATA_W);
    localparam int IDX_W  = idx_width(NBEATS);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NBEATS - 1);

    ser_state_e        state;
    ser_state_e        state_next;
    logic [SUM_W-1:0]  sum_q;
    logic              ovf_q;
    logic [IDX_W-1:0]  idx;
    logic [DATA_W-1:0] beat;
    logic              on_last;
    logic              advance;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            state <= SER_IDLE;
        else
            state <= state_next;
    end

    // A load always restarts at beat 0, even when it lands on the last beat's transfer.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sum_q <= '0;
            ovf_q <= 1'b0;
            idx   <= '0;
        end else if (load) begin
            sum_q <= load_sum;
            ovf_q <= load_ovf;
            idx   <= '0;
        end else if (advance && !on_last) begin
            idx <= idx + 1'b1;
        end
    end

    always_comb begin
        state_next = state;
        beat       = '0;
        for (int k = 0; k < NBEATS; k++) begin
            if (idx == IDX_W'(k))
                beat = sum_q[k*DATA_W +: DATA_W];
        end
        on_last   = (idx == LAST_IDX);
        valid_out = (state == SER_SEND);
        advance   = valid_out && ready_out;
        last_xfer = advance && on_last;
        data_out  = valid_out ? beat : '0;
        end_out   = valid_out && on_last;
        ovf_out   = valid_out && on_last && ovf_q;
        if (load)
            state_next = SER_SEND;
        else if (last_xfer)
            state_next = SER_IDLE;
    end

endmodule

// File: rtl/avst_packet_summer.sv
// Sums every beat of an Avalon-ST packet and emits the result as a multi-beat packet,
// with a one-entry pending buffer so accumulation overlaps the previous drain.
module avst_packet_summer
    import avst_adder_pkg::*;
#(
    parameter int DATA_W   = DEF_DATA_W,
    parameter int SUM_W    = DEF_SUM_W,
    parameter int SATURATE = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] data_in,
    input  logic              valid_in,
    input  logic              end_in,
    output logic              ready_in,
    output logic [DATA_W-1:0] data_out,
    output logic              valid_out,
    output logic              end_out,
    input  logic              ready_out,
    output logic              ovf_out,
    output logic [15:0]       pkt_count
);

    logic [SUM_W-1:0]   acc;
    logic               ovf_acc;
    logic [SUM_W-1:0]   pend_sum;
    logic               pend_ovf;
    logic               pend_full;

    logic [MAX_SUM_W:0] add_res;
    logic [SUM_W-1:0]   add_sum;
    logic               add_ovf;
    logic               unused_add_bits;

    logic               in_xfer;
    logic               end_xfer;
    logic               direct_load;
    logic               ser_load;
    logic [SUM_W-1:0]   ser_sum;
    logic               ser_ovf;
    logic               ser_last;

    assign ready_in = !pend_full;

    always_comb begin
        add_res         = sat_add(MAX_SUM_W'(acc), MAX_SUM_W'(data_in), SUM_W, SATURATE != 0);
        add_sum         = add_res[SUM_W-1:0];
        add_ovf         = add_res[MAX_SUM_W] | ovf_acc;
        unused_add_bits = ^add_res;

        in_xfer  = valid_in && ready_in;
        end_xfer = in_xfer && end_in;

        // Pending is only ever written while the serializer cannot take the result itself.
        direct_load = end_xfer && (!valid_out || ser_last) && !pend_full;
        ser_load    = direct_load || (ser_last && pend_full);
        ser_sum     = pend_full ? pend_sum : add_sum;
        ser_ovf     = pend_full ? pend_ovf : add_ovf;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc     <= '0;
            ovf_acc <= 1'b0;
        end else if (end_xfer) begin
            acc     <= '0;
            ovf_acc <= 1'b0;
        end else if (in_xfer) begin
            acc     <= add_sum;
            ovf_acc <= add_ovf;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pend_full <= 1'b0;
            pend_sum  <= '0;
            pend_ovf  <= 1'b0;
        end else if (end_xfer && !direct_load) begin
            pend_full <= 1'b1;
            pend_sum  <= add_sum;
            pend_ovf  <= add_ovf;
        end else if (ser_last && pend_full) begin
            pend_full <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            pkt_count <= '0;
        else if (ser_last)
            pkt_count <= pkt_count + 16'd1;
    end

    avst_sum_serializer #(
        .DATA_W (DATA_W),
        .SUM_W  (SUM_W)
    ) u_serializer (
        .clk       (clk),
        .reset     (reset),
        .load      (ser_load),
        .load_sum  (ser_sum),
        .load_ovf  (ser_ovf),
        .ready_out (ready_out),
        .data_out  (data_out),
        .valid_out (valid_out),
        .end_out   (end_out),
        .ovf_out   (ovf_out),
        .last_xfer (ser_last)
    );

endmodule

// File: tb/tb_avst_packet_summer.sv
// Directed bench for avst_packet_summer: default, saturating, 8/8 and 4/16 configurations.
module tb_avst_packet_summer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic [7:0]  data_in;
    logic        valid_in;
    logic        end_in;
    logic        ready_out;

    logic        ready_in,   s_ready_in,   b8_ready_in,   n4_ready_in;
    logic [7:0]  data_out,   s_data_out,   b8_data_out;
    logic [3:0]  n4_data_out;
    logic        valid_out,  s_valid_out,  b8_valid_out,  n4_valid_out;
    logic        end_out,    s_end_out,    b8_end_out,    n4_end_out;
    logic        ovf_out,    s_ovf_out,    b8_ovf_out,    n4_ovf_out;
    logic [15:0] pkt_count,  s_pkt_count,  b8_pkt_count,  n4_pkt_count;

    logic [7:0]  b8_data_in;
    logic        b8_valid_in, b8_end_in;
    logic [3:0]  n4_data_in;
    logic        n4_valid_in, n4_end_in;

    int n_cmp;
    int n_bad;

    logic [9:0] q_main[$];
    logic [9:0] q_sat[$];
    logic [9:0] q_b8[$];
    logic [9:0] q_n4[$];

    avst_packet_summer dut (
        .clk(clk), .reset(reset), .data_in(data_in), .valid_in(valid_in), .end_in(end_in),
        .ready_in(ready_in), .data_out(data_out), .valid_out(valid_out), .end_out(end_out),
        .ready_out(ready_out), .ovf_out(ovf_out), .pkt_count(pkt_count)
    );

    avst_packet_summer #(.DATA_W(8), .SUM_W(16), .SATURATE(1)) dut_sat (
        .clk(clk), .reset(reset), .data_in(data_in), .valid_in(valid_in), .end_in(end_in),
        .ready_in(s_ready_in), .data_out(s_data_out), .valid_out(s_valid_out), .end_out(s_end_out),
        .ready_out(ready_out), .ovf_out(s_ovf_out), .pkt_count(s_pkt_count)
    );

    avst_packet_summer #(.DATA_W(8), .SUM_W(8), .SATURATE(0)) dut_b8 (
        .clk(clk), .reset(reset), .data_in(b8_data_in), .valid_in(b8_valid_in), .end_in(b8_end_in),
        .ready_in(b8_ready_in), .data_out(b8_data_out), .valid_out(b8_valid_out), .end_out(b8_end_out),
        .ready_out(1'b1), .ovf_out(b8_ovf_out), .pkt_count(b8_pkt_count)
    );

    avst_packet_summer #(.DATA_W(4), .SUM_W(16), .SATURATE(0)) dut_n4 (
        .clk(clk), .reset(reset), .data_in(n4_data_in), .valid_in(n4_valid_in), .end_in(n4_end_in),
        .ready_in(n4_ready_in), .data_out(n4_data_out), .valid_out(n4_valid_out), .end_out(n4_end_out),
        .ready_out(1'b1), .ovf_out(n4_ovf_out), .pkt_count(n4_pkt_count)
    );

    // Capture every accepted output beat as {ovf, end, data}; inputs change 1 ns after posedge.
    always @(negedge clk) begin
        if (valid_out && ready_out)
            q_main.push_back({ovf_out, end_out, data_out});
        if (s_valid_out && ready_out)
            q_sat.push_back({s_ovf_out, s_end_out, s_data_out});
        if (b8_valid_out)
            q_b8.push_back({b8_ovf_out, b8_end_out, b8_data_out});
        if (n4_valid_out)
            q_n4.push_back({n4_ovf_out, n4_end_out, 4'b0, n4_data_out});
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_output(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        n_cmp++;
        assert (observed === expected) else begin
            n_bad++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    function automatic logic tgt_ready(input int target);
        case (target)
            0:       return ready_in;
            1:       return b8_ready_in;
            default: return n4_ready_in;
        endcase
    endfunction

    // Present one beat and hold it until accepted (bounded), then drop valid.
    task automatic apply_stimulus(input int target, input logic [7:0] data, input logic last);
        case (target)
            0:       begin data_in = data;         end_in = last;    valid_in = 1'b1;    end
            1:       begin b8_data_in = data;      b8_end_in = last; b8_valid_in = 1'b1; end
            default: begin n4_data_in = data[3:0]; n4_end_in = last; n4_valid_in = 1'b1; end
        endcase
        for (int i = 0; i < 40 && !tgt_ready(target); i++)
            step();
        check_output($sformatf("ready_in target %0d", target), 32'(tgt_ready(target)), 32'd1);
        step();
        valid_in    = 1'b0;
        b8_valid_in = 1'b0;
        n4_valid_in = 1'b0;
    endtask

    task automatic pop_beat(input int target, input string tag, input logic [7:0] data,
                            input logic last, input logic ovf);
        logic [9:0] b;
        int         sz;
        b = '0;
        case (target)
            0:       sz = q_main.size();
            1:       sz = q_b8.size();
            2:       sz = q_n4.size();
            default: sz = q_sat.size();
        endcase
        check_output({tag, " present"}, 32'(sz > 0), 32'd1);
        if (sz > 0) begin
            case (target)
                0:       b = q_main.pop_front();
                1:       b = q_b8.pop_front();
                2:       b = q_n4.pop_front();
                default: b = q_sat.pop_front();
            endcase
            check_output({tag, " data"}, 32'(b[7:0]), 32'(data));
            check_output({tag, " end"},  32'(b[8]),   32'(last));
            check_output({tag, " ovf"},  32'(b[9]),   32'(ovf));
        end
    endtask

    initial begin
        n_cmp       = 0;
        n_bad       = 0;
        reset       = 1'b1;
        data_in     = '0;
        valid_in    = 1'b0;
        end_in      = 1'b0;
        ready_out   = 1'b1;
        b8_data_in  = '0;
        b8_valid_in = 1'b0;
        b8_end_in   = 1'b0;
        n4_data_in  = '0;
        n4_valid_in = 1'b0;
        n4_end_in   = 1'b0;
        step();
        step();
        check_output("reset ready_in",  32'(ready_in),  32'd1);
        check_output("reset valid_out", 32'(valid_out), 32'd0);
        check_output("reset end_out",   32'(end_out),   32'd0);
        check_output("reset ovf_out",   32'(ovf_out),   32'd0);
        check_output("reset data_out",  32'(data_out),  32'd0);
        check_output("reset pkt_count", 32'(pkt_count), 32'd0);
        reset = 1'b0;
        step();

        $display("[TB] basic packet");
        apply_stimulus(0, 8'h10, 1'b0);
        apply_stimulus(0, 8'h20, 1'b0);
        check_output("t1 no early valid", 32'(valid_out), 32'd0);
        apply_stimulus(0, 8'h30, 1'b1);
        check_output("t1 latency valid", 32'(valid_out), 32'd1);
        check_output("t1 latency data",  32'(data_out),  32'h60);
        repeat (4) step();
        pop_beat(0, "t1 b0", 8'h60, 1'b0, 1'b0);
        pop_beat(0, "t1 b1", 8'h00, 1'b1, 1'b0);
        check_output("t1 no extra beats", 32'(q_main.size()), 32'd0);
        check_output("t1 pkt_count", 32'(pkt_count), 32'd1);

        $display("[TB] single-beat and back-to-back packets");
        apply_stimulus(0, 8'h05, 1'b1);
        apply_stimulus(0, 8'hFF, 1'b0);
        apply_stimulus(0, 8'h01, 1'b1);
        apply_stimulus(0, 8'h02, 1'b1);
        repeat (8) step();
        pop_beat(0, "t2 a0", 8'h05, 1'b0, 1'b0);
        pop_beat(0, "t2 a1", 8'h00, 1'b1, 1'b0);
        pop_beat(0, "t2 b0", 8'h00, 1'b0, 1'b0);
        pop_beat(0, "t2 b1", 8'h01, 1'b1, 1'b0);
        pop_beat(0, "t2 c0", 8'h02, 1'b0, 1'b0);
        pop_beat(0, "t2 c1", 8'h00, 1'b1, 1'b0);
        check_output("t2 pkt_count", 32'(pkt_count), 32'd4);

        $display("[TB] overflow wrap and saturate");
        q_main.delete();
        q_sat.delete();
        for (int i = 0; i < 258; i++)
            apply_stimulus(0, 8'hFF, (i == 257));
        repeat (6) step();
        pop_beat(0, "t3 wrap b0", 8'hFE, 1'b0, 1'b0);
        pop_beat(0, "t3 wrap b1", 8'h00, 1'b1, 1'b1);
        pop_beat(3, "t3 sat b0",  8'hFF, 1'b0, 1'b0);
        pop_beat(3, "t3 sat b1",  8'hFF, 1'b1, 1'b1);
        apply_stimulus(0, 8'h01, 1'b1);
        repeat (4) step();
        pop_beat(0, "t3 wrap next b0", 8'h01, 1'b0, 1'b0);
        pop_beat(0, "t3 wrap next b1", 8'h00, 1'b1, 1'b0);
        pop_beat(3, "t3 sat next b0",  8'h01, 1'b0, 1'b0);
        pop_beat(3, "t3 sat next b1",  8'h00, 1'b1, 1'b0);

        $display("[TB] backpressure");
        q_main.delete();
        ready_out = 1'b0;
        apply_stimulus(0, 8'h01, 1'b1);
        apply_stimulus(0, 8'h02, 1'b1);
        check_output("t4 ready_in low", 32'(ready_in), 32'd0);
        data_in  = 8'h03;
        end_in   = 1'b1;
        valid_in = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check_output("t4 stall ready_in",  32'(ready_in),  32'd0);
            check_output("t4 stall valid_out", 32'(valid_out), 32'd1);
            check_output("t4 stall data_out",  32'(data_out),  32'h01);
            check_output("t4 stall end_out",   32'(end_out),   32'd0);
        end
        ready_out = 1'b1;
        for (int i = 0; i < 20 && !ready_in; i++)
            step();
        check_output("t4 ready_in back", 32'(ready_in), 32'd1);
        check_output("t4 first drained", 32'(q_main.size()), 32'd2);
        step();
        valid_in = 1'b0;
        end_in   = 1'b0;
        repeat (8) step();
        pop_beat(0, "t4 a0", 8'h01, 1'b0, 1'b0);
        pop_beat(0, "t4 a1", 8'h00, 1'b1, 1'b0);
        pop_beat(0, "t4 b0", 8'h02, 1'b0, 1'b0);
        pop_beat(0, "t4 b1", 8'h00, 1'b1, 1'b0);
        pop_beat(0, "t4 c0", 8'h03, 1'b0, 1'b0);
        pop_beat(0, "t4 c1", 8'h00, 1'b1, 1'b0);
        check_output("t4 pkt_count", 32'(pkt_count), 32'd9);

        $display("[TB] reset mid-operation");
        ready_out = 1'b0;
        apply_stimulus(0, 8'h11, 1'b0);
        apply_stimulus(0, 8'h22, 1'b1);
        check_output("t5 result shown", 32'(data_out), 32'h33);
        ready_out = 1'b1;
        apply_stimulus(0, 8'h01, 1'b0);
        ready_out = 1'b0;
        apply_stimulus(0, 8'h02, 1'b0);
        check_output("t5 mid-drain end_out", 32'(end_out), 32'd1);
        #1;
        reset = 1'b1;
        #1;
        check_output("t5 async valid_out", 32'(valid_out), 32'd0);
        check_output("t5 async end_out",   32'(end_out),   32'd0);
        check_output("t5 async data_out",  32'(data_out),  32'd0);
        check_output("t5 async ovf_out",   32'(ovf_out),   32'd0);
        check_output("t5 async ready_in",  32'(ready_in),  32'd1);
        check_output("t5 async pkt_count", 32'(pkt_count), 32'd0);
        step();
        step();
        reset = 1'b0;
        q_main.delete();
        ready_out = 1'b1;
        apply_stimulus(0, 8'h07, 1'b1);
        repeat (4) step();
        check_output("t5 beat count", 32'(q_main.size()), 32'd2);
        pop_beat(0, "t5 b0", 8'h07, 1'b0, 1'b0);
        pop_beat(0, "t5 b1", 8'h00, 1'b1, 1'b0);
        check_output("t5 pkt_count", 32'(pkt_count), 32'd1);

        $display("[TB] parameter sweep");
        q_b8.delete();
        q_n4.delete();
        apply_stimulus(1, 8'hF0, 1'b0);
        apply_stimulus(1, 8'h20, 1'b1);
        apply_stimulus(1, 8'h05, 1'b1);
        repeat (3) step();
        pop_beat(1, "t6 w8 a", 8'h10, 1'b1, 1'b1);
        pop_beat(1, "t6 w8 b", 8'h05, 1'b1, 1'b0);
        check_output("t6 w8 pkt_count", 32'(b8_pkt_count), 32'd2);
        apply_stimulus(2, 8'h0F, 1'b0);
        apply_stimulus(2, 8'h0F, 1'b0);
        apply_stimulus(2, 8'h01, 1'b1);
        repeat (6) step();
        pop_beat(2, "t6 n4 b0", 8'h0F, 1'b0, 1'b0);
        pop_beat(2, "t6 n4 b1", 8'h01, 1'b0, 1'b0);
        pop_beat(2, "t6 n4 b2", 8'h00, 1'b0, 1'b0);
        pop_beat(2, "t6 n4 b3", 8'h00, 1'b1, 1'b0);
        check_output("t6 n4 pkt_count", 32'(n4_pkt_count), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
